// File: rtl/master_port.sv
// -----------------------------------------------------------------------------
// master_port
//   Initiator end of the single-bit serial system bus. Accepts one parallel
//   read/write request from a local master, shifts the address (and write
//   data) out LSB-first, collects serial read data from the slave and returns
//   a one-cycle completion pulse with the parallel read data.
//
//   Optional feature macro: MASTER_TIMEOUT_EN
//     Defined   -> read-wait watchdog of TIMEOUT cycles; on expiry the
//                  transfer completes with derr=1 and drdata=0.
//     Undefined -> the block waits indefinitely for read data; derr is 0.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   dvalid/dmode      local request strobe / mode (0 read, 1 write)
//   daddr/dwdata      request address / write data
//   dready            idle, request accepted this cycle if dvalid
//   ddone/derr        completion pulse / timeout flag (qualified by ddone)
//   drdata            read data, held until the next read completes
//   mwdata/mmode/mvalid  serial bit, mode and bit-valid towards the slave
//   srdata/svalid     serial read-data bit and its valid from the slave
//   sready/ssplit     slave idle / slave has split the read
// -----------------------------------------------------------------------------
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic                  ddone,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  derr,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready,
  input  logic                  ssplit
);

  localparam int BMAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(BMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_WACK, S_RWAIT, S_RDATA, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;     // shifts right while in ADDR
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;   // shifts right while in WDATA
  logic [DATA_WIDTH-1:0] rsh_q, rsh_d;       // read bits enter at the MSB
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic [CW-1:0]         bcnt_q, bcnt_d;

`ifdef MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          derr_q, derr_d;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsh_q    <= '0;
      drdata_q <= '0;
      bcnt_q   <= '0;
`ifdef MASTER_TIMEOUT_EN
      tcnt_q   <= '0;
      derr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rsh_q    <= rsh_d;
      drdata_q <= drdata_d;
      bcnt_q   <= bcnt_d;
`ifdef MASTER_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      derr_q   <= derr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rsh_d    = rsh_q;
    drdata_d = drdata_q;
    bcnt_d   = bcnt_q;
`ifdef MASTER_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    derr_d   = derr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (dvalid) begin
          mode_d  = dmode;
          addr_d  = daddr;
          wdata_d = dwdata;
          bcnt_d  = '0;
`ifdef MASTER_TIMEOUT_EN
          derr_d  = 1'b0;
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sready) begin
          bcnt_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        addr_d = addr_q >> 1;
        if (bcnt_q == CW'(ADDR_WIDTH - 1)) begin
          bcnt_d  = '0;
          state_d = mode_q ? S_WDATA : S_RWAIT;
`ifdef MASTER_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      S_WDATA: begin
        wdata_d = wdata_q >> 1;
        if (bcnt_q == CW'(DATA_WIDTH - 1)) begin
          bcnt_d  = '0;
          state_d = S_WACK;
        end else begin
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      S_WACK: begin
        // First WACK cycle is skipped: the slave's sready is still stale.
        if (bcnt_q == '0)  bcnt_d  = CW'(1);
        else if (sready)   state_d = S_DONE;
      end
      S_RWAIT, S_RDATA: begin
        // RWAIT and RDATA share the capture path; bcnt is 0 on RWAIT entry.
        if (svalid) begin
          rsh_d                 = rsh_q >> 1;
          rsh_d[DATA_WIDTH-1]   = srdata;
`ifdef MASTER_TIMEOUT_EN
          tcnt_d                = '0;
`endif
          if (bcnt_q == CW'(DATA_WIDTH - 1)) begin
            drdata_d = rsh_d;
            bcnt_d   = '0;
            state_d  = S_DONE;
          end else begin
            bcnt_d  = bcnt_q + CW'(1);
            state_d = S_RDATA;
          end
        end
`ifdef MASTER_TIMEOUT_EN
        else if (!ssplit) begin
          // Counter value equals cycles already spent, so expiry lands DONE
          // exactly TIMEOUT cycles after the last clear.
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            drdata_d = '0;
            derr_d   = 1'b1;
            tcnt_d   = '0;
            bcnt_d   = '0;
            state_d  = S_DONE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state; only dready is looked at
  // by the local master in the same cycle.
  assign dready = (state_q == S_IDLE);
  assign ddone  = (state_q == S_DONE);
  assign mvalid = (state_q == S_ADDR) || (state_q == S_WDATA);
  assign mwdata = (state_q == S_ADDR)  ? addr_q[0]  :
                  (state_q == S_WDATA) ? wdata_q[0] : 1'b0;
  assign mmode  = (state_q != S_IDLE) && mode_q;
  assign drdata = drdata_q;
`ifdef MASTER_TIMEOUT_EN
  assign derr   = derr_q;
`else
  assign derr   = 1'b0;
`endif

endmodule

// File: tb/tb_master_port.sv
module tb_master_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          dvalid, dmode;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dready, ddone, derr, mwdata, mmode, mvalid;
  logic [DW-1:0] drdata;
  logic          srdata, svalid, sready, ssplit;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
    .dwdata(dwdata), .dready(dready), .ddone(ddone), .drdata(drdata),
    .derr(derr), .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready), .ssplit(ssplit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            done;
    logic [DW-1:0] rd;
    bit            err;
    bit            mode;
  } exp_t;

  exp_t exp_q[$];
  bit   bit_q[$];
  int   start_q[$];
  int   len_q[$];

  int            checks = 0;
  int            errors = 0;
  bit            mon_off = 1'b0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT shows bus or completion activity.
  bit prev_mv = 1'b0;
  int run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || mon_off) begin
        prev_mv = 1'b0;
        run     = 0;
      end else begin
        if (mvalid) begin
          if (!prev_mv) begin
            if (start_q.size() > 0) chk("addr_start_cycle", cyc, start_q.pop_front());
            else fail("mvalid_unexpected");
          end
          if (bit_q.size() > 0) chk("mwdata_bit", mwdata, bit_q.pop_front());
          else fail("mwdata_extra_bit");
          if (exp_q.size() > 0) chk("mmode_phase", mmode, exp_q[0].mode);
          run++;
        end else if (prev_mv) begin
          if (len_q.size() > 0) chk("mvalid_run_len", run, len_q.pop_front());
          else fail("mvalid_len_unexpected");
          run = 0;
        end
        prev_mv = mvalid;
        if (dready) chk("idle_mmode", mmode, 0);
        if (ddone) begin
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ddone_cycle", cyc, e.done);
            chk("drdata", drdata, e.rd);
            chk("derr", derr, e.err);
            chk("mmode_done", mmode, e.mode);
          end else fail("ddone_unexpected");
        end
      end
    end
  end

  // One full transaction: expectations are computed from the protocol timing
  // rules, pushed, then the master request and slave responses are driven.
  task automatic run_txn(input bit mode, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdat, input logic [DW-1:0] rdat,
                         input int rd, input int wwait, input int split,
                         input int maxgap, input bit no_ans);
    int   n, t0, a0, r, wk, done, k, c;
    int   sv_c[DW];
    exp_t e;
    n = 0;
    while (!dready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait_cycles", n, 0);
    t0 = cyc;
    a0 = t0 + 2 + rd;          // REQ lasts rd stalled cycles plus one
    r  = a0 + AW;              // RWAIT entry for reads
    wk = a0 + AW + DW;         // WACK entry for writes
    if (mode) begin
      done = wk + 2 + wwait;
    end else if (no_ans) begin
      done = r + TO;
      for (int i = 0; i < DW; i++) sv_c[i] = -1;
    end else begin
      c = r + 2 + split;
      for (int i = 0; i < DW; i++) begin
        if (i > 0) c += 1 + $urandom_range(0, maxgap);
        sv_c[i] = c;
      end
      done = c + 1;
    end
    if (!mode) last_rd = no_ans ? '0 : rdat;
    e.done = done; e.rd = last_rd; e.err = no_ans; e.mode = mode;
    exp_q.push_back(e);
    start_q.push_back(a0);
    len_q.push_back(mode ? AW + DW : AW);
    for (int i = 0; i < AW; i++) bit_q.push_back(addr[i]);
    if (mode) for (int i = 0; i < DW; i++) bit_q.push_back(wdat[i]);

    k = 0;
    for (int cc = t0; cc <= done; cc++) begin
      if (cc == t0) begin
        dvalid = 1'b1; dmode = mode; daddr = addr; dwdata = wdat;
      end else begin
        // Busy-time strobes with junk must be ignored.
        dvalid = ($urandom_range(0, 3) == 0);
        dmode  = 1'($urandom); daddr = AW'($urandom); dwdata = DW'($urandom);
      end
      if (cc == t0)                 sready = 1'($urandom);
      else if (cc <= t0 + rd)       sready = 1'b0;
      else if (cc == t0 + rd + 1)   sready = 1'b1;
      else if (mode && cc == wk)    sready = 1'b1;  // must be ignored
      else if (mode && cc > wk)     sready = (cc > wk + wwait);
      else                          sready = 1'($urandom);
      ssplit = !mode && (cc >= r + 2) && (cc < r + 2 + split);
      if (!mode && !no_ans && k < DW && cc == sv_c[k]) begin
        svalid = 1'b1; srdata = rdat[k]; k++;
      end else begin
        svalid = 1'b0; srdata = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    dvalid = 1'b0; svalid = 1'b0; ssplit = 1'b0; sready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0;
    rst = 1'b1; dvalid = 0; dmode = 0; daddr = '0; dwdata = '0;
    srdata = 0; svalid = 0; sready = 0; ssplit = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dready", dready, 1); chk("rst_ddone", ddone, 0);
    chk("rst_mvalid", mvalid, 0); chk("rst_mwdata", mwdata, 0);
    chk("rst_mmode", mmode, 0);   chk("rst_derr", derr, 0);
    chk("rst_drdata", drdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_txn(1, 12'hA5C, 8'h3B, 8'h00, 0, 0, 0, 0, 0);
    run_txn(0, 12'h123, 8'h00, 8'hC6, 0, 0, 0, 0, 0);
    run_txn(0, 12'h456, 8'h00, 8'h81, 0, 0, 5, 0, 0);
    run_txn(1, 12'h7E1, 8'h5A, 8'h00, 7, 0, 0, 0, 0);

    // Reset in the middle of the address phase.
    mon_off = 1'b1;
    t0 = cyc;
    dvalid = 1'b1; dmode = 1'b1; daddr = 12'hFFF; dwdata = 8'hFF; sready = 1'b1;
    @(posedge clk); #1;
    dvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_mvalid", mvalid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_dready", dready, 1); chk("midrst_ddone", ddone, 0);
    chk("midrst_mvalid", mvalid, 0); chk("midrst_mwdata", mwdata, 0);
    chk("midrst_mmode", mmode, 0);   chk("midrst_derr", derr, 0);
    chk("midrst_drdata", drdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; sready = 1'b0;
    exp_q.delete(); bit_q.delete(); start_q.delete(); len_q.delete();
    last_rd = '0;
    mon_off = 1'b0;
    @(posedge clk); #1;
    run_txn(1, 12'h001, 8'hFF, 8'h00, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 8), 3, 0);
    end

`ifdef MASTER_TIMEOUT_EN
    run_txn(0, 12'h321, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    run_txn(1, 12'h0F0, 8'h11, 8'h00, 0, 0, 0, 0, 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("bits_drained", bit_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
